// File: rtl/instruction_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instruction_fetch_pkg
// Shared definitions for the instruction fetch stage: the instruction word
// width, the NOP word loaded on reset/flush, and the fetch FSM encoding.
// -----------------------------------------------------------------------------
package instruction_fetch_pkg;

  localparam int WORD_W = 16;

  localparam logic [WORD_W-1:0] NOP_WORD = 16'h0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
// Three-cycle fetch engine in front of a synchronous instruction RAM:
// ISSUE drives the read, CAPTURE latches the returned word one cycle later
// and asks the PC to advance, HOLD presents the word until decode takes it.
//
// Ports
//   Clock        sole clock, rising edge
//   Reset        asynchronous, active-low reset
//   PC           current program counter (owned and wrapped outside)
//   MemAddr      instruction RAM read address
//   MemRead      instruction RAM read strobe
//   MemData      RAM read data, valid the cycle after the MemRead edge
//   Stall        decode not ready; keep presenting the current word
//   Flush        branch/jump taken; drop current and in-flight word
//   Instruction  registered instruction word
//   InstrPC      registered address of Instruction
//   InstrValid   Instruction is valid and not yet consumed
//   increment    one-cycle PC advance request
//   PCStep       PC advance amount (constant STEP)
// -----------------------------------------------------------------------------
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [7:0]        STEP = 8'h01,
  parameter logic [WORD_W-1:0] NOP  = NOP_WORD
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [WORD_W-1:0] PC,
  output logic [WORD_W-1:0] MemAddr,
  output logic              MemRead,
  input  logic [WORD_W-1:0] MemData,
  input  logic              Stall,
  input  logic              Flush,
  output logic [WORD_W-1:0] Instruction,
  output logic [WORD_W-1:0] InstrPC,
  output logic              InstrValid,
  output logic              increment,
  output logic [7:0]        PCStep
);

  fetch_state_e      state_r;
  logic [WORD_W-1:0] instr_r;
  logic [WORD_W-1:0] instr_pc_r;
  logic              instr_valid_r;
  logic [WORD_W-1:0] last_addr_r;

  logic [WORD_W-1:0] mem_addr_s;
  logic              mem_read_s;
  logic              increment_s;

  // Fetch FSM and instruction/address registers.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_r       <= IDLE;
      instr_r       <= NOP;
      instr_pc_r    <= 16'h0000;
      instr_valid_r <= 1'b0;
      last_addr_r   <= 16'h0000;
    end else begin
      case (state_r)
        IDLE: begin
          // Flush has nothing to discard here, so it is ignored.
          state_r <= ISSUE;
        end
        ISSUE: begin
          last_addr_r <= PC;
          if (Flush) begin
            state_r <= ISSUE;
          end else begin
            state_r <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (Flush) begin
            // In-flight word is dropped; the previous Instruction stays.
            instr_valid_r <= 1'b0;
            state_r       <= ISSUE;
          end else begin
            // PC still holds the issued address: it advances at this edge.
            instr_r       <= MemData;
            instr_pc_r    <= PC;
            instr_valid_r <= 1'b1;
            state_r       <= HOLD;
          end
        end
        HOLD: begin
          if (Flush) begin
            // Flush wins over Stall.
            instr_valid_r <= 1'b0;
            instr_r       <= NOP;
            state_r       <= ISSUE;
          end else if (!Stall) begin
            instr_valid_r <= 1'b0;
            state_r       <= ISSUE;
          end else begin
            state_r <= HOLD;
          end
        end
        default: begin
          instr_valid_r <= 1'b0;
          state_r       <= IDLE;
        end
      endcase
    end
  end

  // Memory strobes and PC advance request decoded from the current state.
  always_comb begin
    mem_addr_s  = last_addr_r;
    mem_read_s  = 1'b0;
    increment_s = 1'b0;
    case (state_r)
      ISSUE: begin
        mem_addr_s = PC;
        mem_read_s = 1'b1;
      end
      CAPTURE: begin
        if (Flush) begin
          increment_s = 1'b0;
        end else begin
          increment_s = 1'b1;
        end
      end
      IDLE: begin
        mem_read_s = 1'b0;
      end
      HOLD: begin
        mem_read_s = 1'b0;
      end
      default: begin
        mem_read_s  = 1'b0;
        increment_s = 1'b0;
      end
    endcase
  end

  assign MemAddr     = mem_addr_s;
  assign MemRead     = mem_read_s;
  assign increment   = increment_s;
  assign Instruction = instr_r;
  assign InstrPC     = instr_pc_r;
  assign InstrValid  = instr_valid_r;
  assign PCStep      = STEP;

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
// Directed bench for instruction_fetch. The bench owns the PC (advanced by
// one on each increment pulse) and a synchronous RAM whose read data is the
// value held in mem_value at the MemRead edge.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] pc = 16'h0000;
  logic [15:0] MemAddr;
  logic        MemRead;
  logic [15:0] mem_data = 16'h0000;
  logic        Stall = 1'b0;
  logic        Flush = 1'b0;
  logic [15:0] Instruction;
  logic [15:0] InstrPC;
  logic        InstrValid;
  logic        increment;
  logic [7:0]  PCStep;

  logic        pc_load = 1'b0;
  logic [15:0] pc_load_val = 16'h0000;
  logic [15:0] mem_value = 16'h0000;

  int tests_run = 0;
  int tests_failed = 0;

  instruction_fetch dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .PC          (pc),
    .MemAddr     (MemAddr),
    .MemRead     (MemRead),
    .MemData     (mem_data),
    .Stall       (Stall),
    .Flush       (Flush),
    .Instruction (Instruction),
    .InstrPC     (InstrPC),
    .InstrValid  (InstrValid),
    .increment   (increment),
    .PCStep      (PCStep)
  );

  always #5 Clock = ~Clock;

  // PC model: load on request, otherwise advance by STEP (1) on increment.
  always @(posedge Clock) begin
    if (pc_load) begin
      pc <= pc_load_val;
    end else if (increment) begin
      pc <= pc + 16'h0001;
    end
  end

  // Synchronous RAM model: data appears one cycle after the MemRead edge.
  always @(posedge Clock) begin
    if (MemRead) begin
      mem_data <= mem_value;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  localparam logic [15:0] RUN_PCS [3] = '{16'hFFFE, 16'hFFFF, 16'h0000};

  initial begin
    // ---------------- reset state ----------------
    #2 Reset = 1'b0;
    pc_load = 1'b1;
    pc_load_val = 16'h0010;
    mem_value = 16'hA5A5;
    #1;
    check("rst_instr", Instruction, 16'h0000);
    check("rst_ipc", InstrPC, 16'h0000);
    check("rst_valid", InstrValid, 1'b0);
    check("rst_addr", MemAddr, 16'h0000);
    check("rst_read", MemRead, 1'b0);
    check("rst_incr", increment, 1'b0);
    check("rst_step", PCStep, 8'h01);
    tick();
    tick();
    pc_load = 1'b0;
    check("rst_pc_loaded", pc, 16'h0010);
    check("rst_read_hold", MemRead, 1'b0);

    // ---------------- first fetch ----------------
    Reset = 1'b1;
    check("c1_idle_read", MemRead, 1'b0);
    check("c1_idle_incr", increment, 1'b0);
    tick();
    check("c2_read", MemRead, 1'b1);
    check("c2_addr", MemAddr, 16'h0010);
    check("c2_incr", increment, 1'b0);
    tick();
    check("c3_incr", increment, 1'b1);
    check("c3_read", MemRead, 1'b0);
    check("c3_addr_hold", MemAddr, 16'h0010);
    tick();
    check("c4_instr", Instruction, 16'hA5A5);
    check("c4_ipc", InstrPC, 16'h0010);
    check("c4_valid", InstrValid, 1'b1);
    check("c4_incr", increment, 1'b0);
    check("c4_pc", pc, 16'h0011);

    // ---------------- stall in HOLD ----------------
    Stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_instr", Instruction, 16'hA5A5);
      check("stall_valid", InstrValid, 1'b1);
      check("stall_read", MemRead, 1'b0);
      check("stall_incr", increment, 1'b0);
    end
    Stall = 1'b0;
    tick();
    check("unstall_read", MemRead, 1'b1);
    check("unstall_addr", MemAddr, 16'h0011);
    check("unstall_valid", InstrValid, 1'b0);

    // ---------------- flush during CAPTURE ----------------
    mem_value = 16'h1234;
    tick();
    Flush = 1'b1;
    #1;
    check("capflush_incr", increment, 1'b0);
    tick();
    check("capflush_read", MemRead, 1'b1);
    check("capflush_valid", InstrValid, 1'b0);
    check("capflush_instr", Instruction, 16'hA5A5);
    check("capflush_pc", pc, 16'h0011);
    // Flush held in ISSUE keeps re-issuing.
    tick();
    check("issflush_read", MemRead, 1'b1);
    check("issflush_addr", MemAddr, 16'h0011);
    Flush = 1'b0;
    tick();
    check("refetch_incr", increment, 1'b1);
    tick();
    check("refetch_instr", Instruction, 16'h1234);
    check("refetch_ipc", InstrPC, 16'h0011);
    check("refetch_valid", InstrValid, 1'b1);

    // ---------------- flush + stall in HOLD ----------------
    Stall = 1'b1;
    Flush = 1'b1;
    tick();
    check("holdflush_valid", InstrValid, 1'b0);
    check("holdflush_instr", Instruction, 16'h0000);
    check("holdflush_read", MemRead, 1'b1);
    check("holdflush_addr", MemAddr, 16'h0012);
    Stall = 1'b0;
    Flush = 1'b0;

    // ---------------- async reset in CAPTURE ----------------
    tick();
    check("precap_incr", increment, 1'b1);
    #2 Reset = 1'b0;
    #1;
    check("arst_incr", increment, 1'b0);
    check("arst_instr", Instruction, 16'h0000);
    check("arst_ipc", InstrPC, 16'h0000);
    check("arst_valid", InstrValid, 1'b0);
    check("arst_addr", MemAddr, 16'h0000);
    check("arst_read", MemRead, 1'b0);
    check("arst_step", PCStep, 8'h01);
    tick();
    check("arst_pc_kept", pc, 16'h0012);
    check("arst_valid_kept", InstrValid, 1'b0);

    // ---------------- continuous run across PC wrap ----------------
    pc_load = 1'b1;
    pc_load_val = 16'hFFFE;
    mem_value = 16'hBEEF;
    tick();
    pc_load = 1'b0;
    check("run_pc_loaded", pc, 16'hFFFE);
    Reset = 1'b1;
    Flush = 1'b1;  // ignored in IDLE
    tick();
    check("run_idle_flush_read", MemRead, 1'b1);
    Flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k != 0) begin
        tick();
        check("run_issue_read", MemRead, 1'b1);
        check("run_issue_addr", MemAddr, RUN_PCS[k]);
      end
      tick();
      check("run_cap_incr", increment, 1'b1);
      check("run_cap_valid", InstrValid, 1'b0);
      tick();
      check("run_ipc", InstrPC, RUN_PCS[k]);
      check("run_valid", InstrValid, 1'b1);
      check("run_instr", Instruction, 16'hBEEF);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Watchdog so the bench always terminates.
  initial begin
    #20000;
    $display("FAIL watchdog: timeout reached, expected bench completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter STEP, default 8'h01: PC advance per fetched instruction, driven on PCStep.
REQ-002 Parameter NOP, default 16'h0000: instruction-register value after reset or flush.
REQ-003 Clock  in  1  sole clock; all state updates on posedge Clock.
REQ-004 Reset  in  1  asynchronous, active-low reset (Reset=0 resets immediately, regardless of Clock).
REQ-005 PC  in  16  current program-counter value.
REQ-006 MemAddr  out  16  instruction-memory read address.
REQ-007 MemRead  out  1  read strobe to instruction memory.
REQ-008 MemData  in  16  read data, valid exactly one cycle after the MemRead edge (synchronous block RAM).
REQ-009 Stall  in  1  downstream decode not ready; holds the current instruction.
REQ-010 Flush  in  1  branch/jump taken; discards current and in-flight instruction.
REQ-011 Instruction  out  16  registered instruction.
REQ-012 InstrPC  out  16  registered address of Instruction.
REQ-013 InstrValid  out  1  Instruction holds a valid, unconsumed word.
REQ-014 increment  out  1  one-cycle PC advance request.
REQ-015 PCStep  out  8  advance amount; constant STEP.

Function
REQ-016 FSM states: IDLE, ISSUE, CAPTURE, HOLD; state register is the only control state.
REQ-017 IDLE: all strobes 0; next state ISSUE unconditionally (one cycle after reset release).
REQ-018 ISSUE: MemAddr=PC, MemRead=1; next CAPTURE, or stay ISSUE if Flush=1.
REQ-019 CAPTURE, Flush=0: combinational increment=1; at the edge Instruction<=MemData, InstrPC<=PC, InstrValid<=1; next HOLD.
REQ-020 CAPTURE, Flush=1: increment=0, MemData discarded, InstrValid<=0; next ISSUE.
REQ-021 HOLD: Instruction/InstrPC/InstrValid stable; Stall=0 consumes the word (InstrValid<=0, next ISSUE); Stall=1 stays HOLD.
REQ-022 HOLD, Flush=1: InstrValid<=0, Instruction<=NOP, next ISSUE; Flush takes priority over Stall.
REQ-023 increment asserted only in CAPTURE with Flush=0; never two consecutive cycles.
REQ-024 MemRead asserted only in ISSUE; MemAddr=PC in ISSUE, otherwise holds last issued address.
REQ-025 Throughput: one instruction per 3 cycles when Stall=0 and Flush=0.
REQ-026 Flush in IDLE ignored.
REQ-027 PC wrap 16'hFFFF->16'h0000 is owned by the PC; fetch applies no address arithmetic.

Reset
REQ-028 Reset=0 forces: state=IDLE, Instruction=NOP, InstrPC=16'h0000, InstrValid=0, MemAddr=16'h0000, MemRead=0, increment=0.
REQ-029 Reset assertion mid-CAPTURE aborts the capture; no increment pulse or register update follows.
REQ-030 PCStep=STEP at all times, including during reset.

Structure
REQ-031 Shared package holds the state encoding (2-bit, IDLE=0, ISSUE=1, CAPTURE=2, HOLD=3), the NOP constant, and the 16-bit word width.
REQ-032 No sub-module; one sequential state/register process plus one combinational output process.

Verification
REQ-033 Reset release, PC=16'h0010, MemData=16'hA5A5, Stall=0 -> MemRead at cycle 2, increment at cycle 3, Instruction=16'hA5A5, InstrPC=16'h0010, InstrValid=1 at cycle 4.
REQ-034 Stall=1 held 5 cycles in HOLD -> Instruction unchanged, MemRead=0, increment=0 throughout; ISSUE one cycle after Stall=0.
REQ-035 Flush=1 during CAPTURE with MemData=16'h1234 -> no increment, InstrValid=0, Instruction keeps prior value, next state ISSUE.
REQ-036 Flush=1 and Stall=1 together in HOLD -> InstrValid=0, Instruction=NOP, next state ISSUE.
REQ-037 Reset=0 pulse asynchronous to Clock during CAPTURE -> all outputs at reset values immediately, no increment pulse.
REQ-038 Continuous run, Stall=0, PC incremented by bench model from 16'hFFFE -> fetched InstrPC sequence 16'hFFFE, 16'hFFFF, 16'h0000, one every 3 cycles.
